output_capture: RTL and testbench

OUTPUT_CAPTURE -- requirements
Module: output_capture

---
 rtl/output_capture_if.sv | 28 ++
 rtl/output_capture.sv | 121 ++++++++++++
 tb/tb_output_capture.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/output_capture_if.sv
// Bundles the snooped IRAM write port, the capture controls and the output stream into one
// interface.
interface output_capture_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              enable;
    logic              wren;
    logic [ADDR_W-1:0] IRAM_address;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [15:0]       count;
    logic              overflow;
    logic              done;

    modport master (
        output enable, wren, IRAM_address, data, out_ready,
        input  out_data, out_valid, out_last, count, overflow, done
    );

    modport slave (
        input  enable, wren, IRAM_address, data, out_ready,
        output out_data, out_valid, out_last, count, overflow, done
    );
endinterface

// File: rtl/output_capture.sv
// Snoops IRAM writes to CAP_ADDR into a FWFT FIFO, one frame of FRAME_LEN hits per enable.
// Define OUTCAP_LAST_EN to tag the frame's final word and drive out_last.
module output_capture #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned CAP_ADDR   = 80,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FRAME_LEN  = 256
) (
    input logic             clock,
    input logic             reset,
    output_capture_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [15:0] FRAME_LEN16 = 16'(FRAME_LEN);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StCapture, StDrain, StDone} state_e;

    state_e            state_q;
    logic [15:0]       count_q;
    logic              overflow_q;
    logic              done_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic hit, cap_hit, frame_end, out_valid, pop, push;

    always_comb begin
        hit       = bus.wren && (bus.IRAM_address == ADDR_W'(CAP_ADDR));
        // An abort edge (enable low) never captures, even with a hit present.
        cap_hit   = (state_q == StCapture) && bus.enable && hit;
        frame_end = cap_hit && ((count_q + 16'd1) == FRAME_LEN16);
        out_valid = (occ_q != '0);
        pop       = out_valid && bus.out_ready;
        push      = cap_hit && ((occ_q != FULL_OCC) || pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.enable) begin
                        state_q    <= StCapture;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                StCapture: begin
                    if (!bus.enable) begin
                        state_q <= StDrain;
                    end else if (cap_hit) begin
                        if (count_q != FRAME_LEN16) count_q <= count_q + 16'd1;
                        if (!push) overflow_q <= 1'b1;
                        if (frame_end) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (occ_q == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    if (!bus.enable) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage needs no reset: occ_q gates every read.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= bus.data;
    end

`ifdef OUTCAP_LAST_EN
    logic tag_mem [FIFO_DEPTH];

    always_ff @(posedge clock) begin
        if (push) tag_mem[wr_ptr_q] <= frame_end;
    end

    assign bus.out_last = out_valid && tag_mem[rd_ptr_q];
`else
    assign bus.out_last = 1'b0;
`endif

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? mem[rd_ptr_q] : '0;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_output_capture.sv
// Directed bench: instance a (depth 4, frame 4) and instance b (depth 4, frame 6).
// Define OUTCAP_LAST_EN for both DUT and bench to exercise the last-word tag.
module tb_output_capture;
    logic clock;
    logic reset;
    int   checks;
    int   errors;
    bit   last_seen;

    output_capture_if #(.DATA_W(8), .ADDR_W(8)) a_if ();
    output_capture_if #(.DATA_W(8), .ADDR_W(8)) b_if ();

    output_capture #(
        .DATA_W(8), .ADDR_W(8), .CAP_ADDR(80), .FIFO_DEPTH(4), .FRAME_LEN(4)
    ) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (a_if.slave)
    );

    output_capture #(
        .DATA_W(8), .ADDR_W(8), .CAP_ADDR(80), .FIFO_DEPTH(4), .FRAME_LEN(6)
    ) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (b_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (a_if.out_last === 1'b1) last_seen = 1'b1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic hit_a(input logic [7:0] d);
        a_if.wren = 1'b1; a_if.IRAM_address = 8'd80; a_if.data = d;
        tick();
        a_if.wren = 1'b0;
    endtask

    task automatic hit_b(input logic [7:0] d);
        b_if.wren = 1'b1; b_if.IRAM_address = 8'd80; b_if.data = d;
        tick();
        b_if.wren = 1'b0;
    endtask

    task automatic wait_done(input bit sel_b, input string tag);
        for (int i = 0; i < 20; i++) begin
            if ((sel_b ? b_if.done : a_if.done) === 1'b1) break;
            tick();
        end
        check(tag, 32'(sel_b ? b_if.done : a_if.done), 32'd1);
    endtask

    initial begin
        logic exp_last;
        checks = 0;
        errors = 0;
        last_seen = 1'b0;
`ifdef OUTCAP_LAST_EN
        exp_last = 1'b1;
`else
        exp_last = 1'b0;
`endif
        reset = 1'b1;
        a_if.enable = 0; a_if.wren = 0; a_if.IRAM_address = 0; a_if.data = 0; a_if.out_ready = 0;
        b_if.enable = 0; b_if.wren = 0; b_if.IRAM_address = 0; b_if.data = 0; b_if.out_ready = 0;
        #1;
        check("rst_valid", 32'(a_if.out_valid), 0);
        check("rst_data", 32'(a_if.out_data), 0);
        check("rst_count", 32'(a_if.count), 0);
        check("rst_done", 32'(a_if.done), 0);
        check("rst_ovf", 32'(a_if.overflow), 0);
        check("rst_last", 32'(a_if.out_last), 0);
        tick();
        reset = 1'b0;
        tick();

        // Non-matching writes are not captured.
        a_if.enable = 1'b1;
        tick();
        a_if.wren = 1; a_if.IRAM_address = 8'd79; a_if.data = 8'd5;
        tick();
        a_if.IRAM_address = 8'd81;
        tick();
        a_if.wren = 0; a_if.IRAM_address = 8'd80;
        tick();
        check("nohit_valid", 32'(a_if.out_valid), 0);
        check("nohit_count", 32'(a_if.count), 0);

        // Basic frame of four with a ready consumer.
        a_if.out_ready = 1'b1;
        hit_a(8'd10);
        check("f4_d10", 32'(a_if.out_data), 10);
        check("f4_v10", 32'(a_if.out_valid), 1);
        check("f4_l10", 32'(a_if.out_last), 0);
        hit_a(8'd20);
        check("f4_d20", 32'(a_if.out_data), 20);
        hit_a(8'd30);
        check("f4_d30", 32'(a_if.out_data), 30);
        hit_a(8'd40);
        check("f4_d40", 32'(a_if.out_data), 40);
        check("f4_l40", 32'(a_if.out_last), 32'(exp_last));
        check("f4_count", 32'(a_if.count), 4);
        check("f4_done_early", 32'(a_if.done), 0);
        tick();
        check("f4_empty", 32'(a_if.out_valid), 0);
        check("f4_empty_data", 32'(a_if.out_data), 0);
        wait_done(1'b0, "f4_done");
        check("f4_count_end", 32'(a_if.count), 4);
        a_if.enable = 1'b0;
        tick();
        check("f4_idle_done", 32'(a_if.done), 0);

        // Overflow frame on instance b: 6 hits into a depth-4 FIFO with no consumer.
        b_if.enable = 1'b1;
        tick();
        for (int i = 1; i <= 6; i++) hit_b(8'(i));
        check("ovf_valid", 32'(b_if.out_valid), 1);
        check("ovf_head", 32'(b_if.out_data), 1);
        check("ovf_flag", 32'(b_if.overflow), 1);
        check("ovf_count", 32'(b_if.count), 6);
        tick();
        tick();
        check("ovf_drain_hold", 32'(b_if.done), 0);
        b_if.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("ovf_read", 32'(b_if.out_data), 32'(i));
            tick();
        end
        check("ovf_empty", 32'(b_if.out_valid), 0);
        wait_done(1'b1, "ovf_done");
        b_if.enable = 1'b0;
        tick();
        check("ovf_idle_done", 32'(b_if.done), 0);

        // Hit on a full FIFO while popping is accepted.
        b_if.enable = 1'b1; b_if.out_ready = 1'b0;
        tick();
        check("full_ovf_clr", 32'(b_if.overflow), 0);
        check("full_cnt_clr", 32'(b_if.count), 0);
        for (int i = 1; i <= 4; i++) hit_b(8'(i));
        check("full_count4", 32'(b_if.count), 4);
        b_if.out_ready = 1'b1;
        hit_b(8'd5);
        b_if.out_ready = 1'b0;
        check("full_pp_ovf", 32'(b_if.overflow), 0);
        check("full_pp_head", 32'(b_if.out_data), 2);
        check("full_pp_count", 32'(b_if.count), 5);
        hit_b(8'd6);
        check("full_still4", 32'(b_if.overflow), 1);
        check("full_count6", 32'(b_if.count), 6);
        b_if.out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            check("full_read", 32'(b_if.out_data), 32'(i));
            tick();
        end
        check("full_empty", 32'(b_if.out_valid), 0);
        wait_done(1'b1, "full_done");
        b_if.enable = 1'b0;
        tick();

        // Asynchronous reset mid-frame.
        a_if.out_ready = 1'b0; a_if.enable = 1'b1;
        tick();
        hit_a(8'd1);
        hit_a(8'd2);
        check("mid_count2", 32'(a_if.count), 2);
        check("mid_valid", 32'(a_if.out_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(a_if.out_valid), 0);
        check("ar_data", 32'(a_if.out_data), 0);
        check("ar_count", 32'(a_if.count), 0);
        check("ar_done", 32'(a_if.done), 0);
        check("ar_ovf", 32'(a_if.overflow), 0);
        tick();
        reset = 1'b0;
        tick();
        check("ar_restart_cnt", 32'(a_if.count), 0);
        check("ar_restart_vld", 32'(a_if.out_valid), 0);
        hit_a(8'd7);
        check("ar_new_count", 32'(a_if.count), 1);
        check("ar_new_data", 32'(a_if.out_data), 7);
        a_if.enable = 1'b0; a_if.out_ready = 1'b1;
        tick();
        wait_done(1'b0, "ar_done_end");
        tick();
        check("ar_idle", 32'(a_if.done), 0);

        // Abort after two hits; the hit on the abort edge is ignored.
        a_if.enable = 1'b1;
        tick();
        last_seen = 1'b0;
        hit_a(8'd11);
        check("ab_d11", 32'(a_if.out_data), 11);
        hit_a(8'd22);
        check("ab_d22", 32'(a_if.out_data), 22);
        a_if.enable = 1'b0;
        hit_a(8'd99);
        check("ab_empty", 32'(a_if.out_valid), 0);
        check("ab_count", 32'(a_if.count), 2);
        wait_done(1'b0, "ab_done");
        check("ab_nolast", 32'(last_seen), 0);
        tick();
        check("ab_idle", 32'(a_if.done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
